// File: rtl/simplebus_arbiter.sv
// ============================================================================
// simplebus_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares one simplebus between NUM_LEADERS leaders.
// A grant is held for one whole transaction: the start/upper-address cycle,
// the mid-address cycle, the low-address cycle, and then the data phase. The
// grant is released when dataValid completes the data phase. It is also
// released when the data phase runs TIMEOUT cycles with no follower
// answering. The block only watches start, read and dataValid, and drives
// nothing onto the bus itself.
//
// Ports
//   clock       in   bus clock; all state changes on posedge
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_LEADERS] per-leader level request
//   start       in   observed bus start strobe from the granted leader
//   read        in   observed read strobe, sampled in the low-address cycle
//   dataValid   in   observed dataValid (tri-state net); only 1'b1 counts
//   grant       out  [NUM_LEADERS] registered one-hot grant
//   busy        out  high while any grant is held
//   xfer_read   out  direction latched for the current/last transaction
//   done        out  one-cycle pulse on normal completion
//   timeout     out  one-cycle pulse on timeout abort
//   timeout_id  out  [$clog2(NUM_LEADERS)] leader of the last timed-out txn
// ============================================================================

// ----------------------------------------------------------------------------
// Per-leader cell. It flags a request whose index lies strictly above the
// round-robin pointer. Those requests have priority over the ones that must
// wrap around through index 0.
// ----------------------------------------------------------------------------
module simplebus_arbiter_lane #(
    parameter int IW   = 2,
    parameter int LANE = 0
) (
    input  logic          req_bit,
    input  logic [IW-1:0] last,
    output logic          hi_req
);
    assign hi_req = req_bit && (LANE > int'(last));
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module simplebus_arbiter #(
    parameter int NUM_LEADERS = 4,
    parameter int TIMEOUT     = 16,
    parameter int CW          = $clog2(TIMEOUT + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_LEADERS-1:0]         req,
    input  logic                           start,
    input  logic                           read,
    input  logic                           dataValid,
    output logic [NUM_LEADERS-1:0]         grant,
    output logic                           busy,
    output logic                           xfer_read,
    output logic                           done,
    output logic                           timeout,
    output logic [$clog2(NUM_LEADERS)-1:0] timeout_id
);

    localparam int IW = $clog2(NUM_LEADERS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANTED  = 3'd1,
        S_ADDR_MID = 3'd2,
        S_ADDR_LO  = 3'd3,
        S_DATA     = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,      state_d;
    logic [NUM_LEADERS-1:0] grant_q,      grant_d;
    logic [IW-1:0]          gidx_q,       gidx_d;       // index of current grantee
    logic [IW-1:0]          last_q,       last_d;       // round-robin pointer
    logic                   xfer_read_q,  xfer_read_d;
    logic                   done_q,       done_d;
    logic                   timeout_q,    timeout_d;
    logic [IW-1:0]          timeout_id_q, timeout_id_d;
    logic [CW-1:0]          cnt_q,        cnt_d;

    // ------------------------------------------------------------------
    // dataValid comes from a tri-state net. A floating or unknown value
    // must not complete a transaction, so only a definite 1 counts. Logic
    // synthesis treats this as a plain equality test.
    // ------------------------------------------------------------------
    logic dv_on;
    assign dv_on = (dataValid === 1'b1);

    // ------------------------------------------------------------------
    // Round-robin winner. Requests above the pointer win first. If there
    // are none, the search wraps and takes the lowest request overall. In
    // both cases the winner is the lowest set bit of the chosen set.
    // ------------------------------------------------------------------
    logic [NUM_LEADERS-1:0] hi_req;
    logic [NUM_LEADERS-1:0] sel_req;
    logic [IW-1:0]          win;

    for (genvar g = 0; g < NUM_LEADERS; g++) begin : g_lane
        simplebus_arbiter_lane #(
            .IW   (IW),
            .LANE (g)
        ) u_lane (
            .req_bit (req[g]),
            .last    (last_q),
            .hi_req  (hi_req[g])
        );
    end

    always_comb begin
        sel_req = (|hi_req) ? hi_req : req;
        win     = '0;
        for (int i = NUM_LEADERS - 1; i >= 0; i--) begin
            if (sel_req[i]) win = IW'(i);
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_d       = last_q;
        xfer_read_d  = xfer_read_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;

        unique case (state_q)
            S_IDLE: begin
                // Every path out of a grant lands here. That guarantees at
                // least one cycle of bus turnaround between grants.
                if (|req) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    gidx_d       = win;
                    state_d      = S_GRANTED;
                end
            end

            S_GRANTED: begin
                if (start) begin
                    state_d = S_ADDR_MID;
                end else if (!req[gidx_q]) begin
                    // The leader withdrew before starting. The pointer is
                    // not advanced, so this leader keeps its priority.
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end

            S_ADDR_MID: begin
                state_d = S_ADDR_LO;
            end

            S_ADDR_LO: begin
                xfer_read_d = read;
                cnt_d       = '0;
                state_d     = S_DATA;
            end

            S_DATA: begin
                cnt_d = cnt_q + CW'(1);
                // Completion is tested first, so dataValid in the last
                // allowed cycle still counts as a normal finish.
                if (dv_on) begin
                    grant_d = '0;
                    done_d  = 1'b1;
                    last_d  = gidx_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    grant_d      = '0;
                    timeout_d    = 1'b1;
                    timeout_id_d = gidx_q;
                    last_d       = gidx_q;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_q       <= IW'(NUM_LEADERS - 1);   // leader 0 goes first
            xfer_read_q  <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            xfer_read_q  <= xfer_read_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = |grant_q;
    assign xfer_read  = xfer_read_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule
